// File: rtl/fsquare.sv
// Three-stage binary32 squarer: unpack/classify, 24x24 multiply, normalise/round/pack.
// Fixed 3-cycle latency, one operand per cycle, no backpressure; sign is always cleared.
module fsquare #(
    parameter bit ROUND = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_valid,
    output logic [31:0] result,
    output logic        out_valid
);

    // Stage 1: classification, significand and provisional exponent
    logic               v1_q;
    logic               zero1_q;
    logic               spec1_q;
    logic [23:0]        m1_q;
    logic signed [9:0]  e1_q;
    logic signed [9:0]  e1_d;

    // Stage 2: product and piped metadata
    logic               v2_q;
    logic               zero2_q;
    logic               spec2_q;
    logic signed [9:0]  e2_q;
    logic [47:0]        p2_q;

    // Stage 3: packed result
    logic               v3_q;
    logic [31:0]        res_q;
    logic [31:0]        res_d;

    logic [22:0]        mant_raw;
    logic               rbit;
    logic [23:0]        mant_rnd;
    logic [22:0]        mant_fin;
    logic signed [9:0]  e_norm;
    logic signed [9:0]  e_fin;

    logic               sign_unused;
    logic [21:0]        p_low_unused;

    assign sign_unused  = input_a[31];
    assign p_low_unused = p2_q[21:0];

    // 2*e - 127 in 10-bit signed covers -125..381 without wrapping
    assign e1_d = $signed({1'b0, input_a[30:23], 1'b0} - 10'd127);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            zero1_q <= 1'b0;
            spec1_q <= 1'b0;
            m1_q    <= '0;
            e1_q    <= '0;
            v2_q    <= 1'b0;
            zero2_q <= 1'b0;
            spec2_q <= 1'b0;
            e2_q    <= '0;
            p2_q    <= '0;
            v3_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            v1_q    <= input_valid;
            zero1_q <= (input_a[30:23] == 8'h00);
            spec1_q <= (input_a[30:23] == 8'hFF);
            m1_q    <= {1'b1, input_a[22:0]};
            e1_q    <= e1_d;
            v2_q    <= v1_q;
            zero2_q <= zero1_q;
            spec2_q <= spec1_q;
            e2_q    <= e1_q;
            p2_q    <= m1_q * m1_q;
            v3_q    <= v2_q;
            res_q   <= res_d;
        end
    end

    always_comb begin
        mant_raw = p2_q[45:23];
        rbit     = p2_q[22];
        e_norm   = e2_q;
        if (p2_q[47]) begin
            mant_raw = p2_q[46:24];
            rbit     = p2_q[23];
            e_norm   = e2_q + 10'sd1;
        end

        mant_rnd = {1'b0, mant_raw} + {23'd0, ROUND & rbit};
        mant_fin = mant_rnd[22:0];
        e_fin    = e_norm;
        if (mant_rnd[23]) begin
            mant_fin = '0;
            e_fin    = e_norm + 10'sd1;
        end

        // Range checks use the exponent after the rounding carry
        res_d = {1'b0, e_fin[7:0], mant_fin};
        if (zero2_q) begin
            res_d = 32'h0000_0000;
        end else if (spec2_q) begin
            res_d = 32'h7F80_0000;
        end else if (e_fin >= 10'sd255) begin
            res_d = 32'h7F80_0000;
        end else if (e_fin <= 10'sd0) begin
            res_d = 32'h0000_0000;
        end
    end

    assign result    = res_q;
    assign out_valid = v3_q;

endmodule

// File: tb/tb_fsquare.sv
// Scoreboarded bench for fsquare: directed values, streaming, valid gaps,
// mid-stream reset, and a truncating instance driven in parallel.
module tb_fsquare;

    logic        clk;
    logic        rst;
    logic [31:0] input_a;
    logic        input_valid;
    logic [31:0] result;
    logic        out_valid;
    logic [31:0] result0;
    logic        out_valid0;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        logic [31:0] a;
        logic [31:0] exp1;
        logic [31:0] exp0;
        int          cyc;
    } item_t;

    item_t sb[$];

    fsquare #(.ROUND(1'b1)) dut (
        .clk(clk), .rst(rst), .input_a(input_a), .input_valid(input_valid),
        .result(result), .out_valid(out_valid)
    );

    fsquare #(.ROUND(1'b0)) dut0 (
        .clk(clk), .rst(rst), .input_a(input_a), .input_valid(input_valid),
        .result(result0), .out_valid(out_valid0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: integer significand square, explicit shift choice
    function automatic logic [31:0] model(input logic [31:0] a, input bit rnd);
        int                 e;
        int                 ex;
        int                 sh;
        longint unsigned    m;
        longint unsigned    p;
        longint unsigned    mant;
        longint unsigned    rb;
        logic [31:0]        r;
        e = int'(a[30:23]);
        if (e == 0) return 32'h0000_0000;
        if (e == 255) return 32'h7F80_0000;
        m  = 64'h80_0000 | longint'(a[22:0]);
        p  = m * m;
        ex = 2 * e - 127;
        sh = 23;
        if (p >= 64'h8000_0000_0000) begin
            sh = 24;
            ex = ex + 1;
        end
        mant = (p >> sh) & 64'h7F_FFFF;
        rb   = (p >> (sh - 1)) & 64'h1;
        if (rnd && rb == 1) mant = mant + 1;
        if (mant == 64'h80_0000) begin
            mant = 0;
            ex   = ex + 1;
        end
        if (ex >= 255) return 32'h7F80_0000;
        if (ex <= 0) return 32'h0000_0000;
        r = {1'b0, ex[7:0], mant[22:0]};
        return r;
    endfunction

    // Drive one cycle; valid operands are pushed with their expectations
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] e1, input logic [31:0] e0);
        item_t it;
        input_valid = v;
        input_a     = a;
        if (v) begin
            it.a    = a;
            it.exp1 = e1;
            it.exp0 = e0;
            it.cyc  = cyc;
            sb.push_back(it);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] e1, input logic [31:0] e0);
        step(1'b1, a, e1, e0);
    endtask

    task automatic sendm(input logic [31:0] a);
        step(1'b1, a, model(a, 1'b1), model(a, 1'b0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        item_t it;
        if (out_valid || out_valid0) begin
            chk("valid_match", {31'd0, out_valid0}, {31'd0, out_valid});
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_output observed=%h expected=no_output", result);
            end
            if (sb.size() != 0) begin
                it = sb.pop_front();
                chk($sformatf("result_r1(%h)", it.a), result, it.exp1);
                chk($sformatf("result_r0(%h)", it.a), result0, it.exp0);
                chk($sformatf("latency(%h)", it.a), cyc, it.cyc + 3);
            end
        end
    end

    initial begin
        logic [31:0] r;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        input_valid = 1'b0;
        input_a     = 32'h0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_valid", {31'd0, out_valid}, 32'h0);
        chk("reset_result_r0", result0, 32'h0);
        rst = 1'b0;
        idle(3);
        chk("idle_valid", {31'd0, out_valid}, 32'h0);

        // Single shots with gaps
        send(32'h4040_0000, 32'h4110_0000, 32'h4110_0000);
        idle(4);
        send(32'h3FC0_0000, 32'h4010_0000, 32'h4010_0000);
        idle(4);
        send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        idle(4);

        // Sign, zero, denormal, specials, limits
        send(32'hC000_0000, 32'h4080_0000, 32'h4080_0000);
        send(32'h8000_0000, 32'h0000_0000, 32'h0000_0000);
        send(32'h0000_0001, 32'h0000_0000, 32'h0000_0000);
        send(32'hFF80_0000, 32'h7F80_0000, 32'h7F80_0000);
        send(32'h7FC0_0000, 32'h7F80_0000, 32'h7F80_0000);
        send(32'h5F80_0000, 32'h7F80_0000, 32'h7F80_0000);
        send(32'h5F7F_FFFF, 32'h7F7F_FFFE, 32'h7F7F_FFFE);
        send(32'h1E3C_E508, 32'h0000_0000, 32'h0000_0000);
        // Rounding versus truncation
        send(32'h3F80_0001, 32'h3F80_0002, 32'h3F80_0002);
        send(32'h3F80_0800, 32'h3F80_1001, 32'h3F80_1000);
        idle(4);

        // Back-to-back random normal operands
        for (int i = 0; i < 100; i++) begin
            r        = $urandom;
            r[30:23] = 8'($urandom_range(254, 1));
            sendm(r);
        end
        idle(4);

        // Valid gap pattern 1,0,1,1,0
        for (int k = 0; k < 2; k++) begin
            r = $urandom; r[30:23] = 8'($urandom_range(200, 60)); sendm(r);
            idle(1);
            r = $urandom; r[30:23] = 8'($urandom_range(200, 60)); sendm(r);
            r = $urandom; r[30:23] = 8'($urandom_range(200, 60)); sendm(r);
            idle(1);
        end
        idle(4);
        chk("drain_before_reset", sb.size(), 0);

        // Reset with three operands in flight; the operand on the reset edge is refused
        sendm(32'h4040_0000);
        sendm(32'h3FC0_0000);
        sendm(32'h4000_0000);
        rst         = 1'b1;
        input_valid = 1'b1;
        input_a     = 32'h4100_0000;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        chk("midreset_valid", {31'd0, out_valid}, 32'h0);
        chk("midreset_result", result, 32'h0);
        chk("midreset_valid_r0", {31'd0, out_valid0}, 32'h0);
        rst = 1'b0;
        idle(6);
        send(32'h4040_0000, 32'h4110_0000, 32'h4110_0000);
        idle(2);
        chk("post_reset_pending", sb.size(), 1);

        for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
        chk("final_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
